mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/mem_access_ctrl_if.sv | 43 ++++
 rtl/lane_align.sv | 53 +++++
 rtl/mem_access_ctrl.sv | 128 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store memory access controller:
// access sizes, controller states and the default acknowledge timeout.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_ILLEGAL = 2'b00,
    SZ_BYTE    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_DWORD   = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int TIMEOUT_DEFAULT = 16;

  // Words must sit on a 4-byte boundary, doublewords on an 8-byte one.
  function automatic logic access_legal(input logic [1:0] size, input logic [2:0] offset);
    logic ok;
    ok = 1'b0;
    case (size)
      SZ_BYTE:  ok = 1'b1;
      SZ_WORD:  ok = (offset[1:0] == 2'b00);
      SZ_DWORD: ok = (offset == 3'b000);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bundles for the controller: the CPU-facing load/store request side and the
// RAM-facing request/response side, each with master/slave views.
interface mem_access_ctrl_if;
  logic        start;
  logic        mem_write_en;
  logic [1:0]  size;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [63:0] rdata;

  modport master (
    output start, mem_write_en, size, addr, wdata,
    input  busy, done, fault, rdata
  );

  modport slave (
    input  start, mem_write_en, size, addr, wdata,
    output busy, done, fault, rdata
  );
endinterface

interface mem_ram_if;
  logic        req;
  logic        we;
  logic [63:0] addr;
  logic [7:0]  be;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        ack;

  modport master (
    output req, we, addr, be, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/lane_align.sv
// Combinational byte-lane steering between a right-justified CPU operand and
// the 64-bit RAM bus: byte enables, store shift and load extract/zero-extend.
module lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [2:0]  offset,
  input  logic [63:0] wdata_in,
  input  logic [63:0] rdata_in,
  output logic [7:0]  byte_en,
  output logic [63:0] wdata_out,
  output logic [63:0] rdata_out
);

  logic [5:0]  shamt;
  logic [63:0] size_mask;
  logic [63:0] rd_shifted;

  assign shamt = {offset, 3'b000};

  always_comb begin
    byte_en   = 8'h00;
    wdata_out = wdata_in;
    size_mask = 64'h0;
    case (size)
      SZ_BYTE: begin
        byte_en   = 8'h01 << offset;
        wdata_out = wdata_in << shamt;
        size_mask = 64'h0000_0000_0000_00FF;
      end
      SZ_WORD: begin
        byte_en   = 8'h0F << offset;
        wdata_out = wdata_in << shamt;
        size_mask = 64'h0000_0000_FFFF_FFFF;
      end
      SZ_DWORD: begin
        byte_en   = 8'hFF;
        wdata_out = wdata_in;
        size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      default: begin
        byte_en   = 8'h00;
        wdata_out = wdata_in;
        size_mask = 64'h0;
      end
    endcase
  end

  // Doublewords are always aligned, so the shift is zero for them.
  assign rd_shifted = rdata_in >> shamt;
  assign rdata_out  = rd_shifted & size_mask;

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store memory access controller: validates alignment, issues one RAM
// request per accepted access, waits up to TIMEOUT cycles for ram_ack.
module mem_access_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_ctrl_if.slave  cpu,
  mem_ram_if.master         ram
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              fault_q, fault_d;
  logic [63:0]       rdata_q, rdata_d;
  logic [63:0]       addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              we_q, we_d;

  logic [7:0]        lane_be;
  logic [63:0]       lane_wdata;
  logic [63:0]       lane_rdata;
  logic              start_legal;

  // RAM-side lanes derive from the latched access, so they stay stable for
  // the whole request and read as zero straight out of reset.
  lane_align u_lane_align (
    .size      (size_q),
    .offset    (addr_q[2:0]),
    .wdata_in  (wdata_q),
    .rdata_in  (ram.rdata),
    .byte_en   (lane_be),
    .wdata_out (lane_wdata),
    .rdata_out (lane_rdata)
  );

  assign start_legal = access_legal(cpu.size, cpu.addr[2:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      fault_q <= 1'b0;
      rdata_q <= 64'h0;
      addr_q  <= 64'h0;
      wdata_q <= 64'h0;
      size_q  <= 2'b00;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    we_d    = we_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu.start) begin
          addr_d  = cpu.addr;
          wdata_d = cpu.wdata;
          size_d  = cpu.size;
          we_d    = cpu.mem_write_en;
          wait_d  = '0;
          if (start_legal) begin
            fault_d = 1'b0;
            state_d = ST_REQ;
          end else begin
            fault_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_REQ: begin
        // An ack on the last allowed cycle still wins over the timeout.
        if (ram.ack) begin
          fault_d = 1'b0;
          state_d = ST_DONE;
          if (!we_q) begin
            rdata_d = lane_rdata;
          end
        end else if (wait_q == WAIT_LAST) begin
          fault_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cpu.busy  = (state_q != ST_IDLE);
  assign cpu.done  = (state_q == ST_DONE);
  assign cpu.fault = fault_q;
  assign cpu.rdata = rdata_q;

  assign ram.req   = (state_q == ST_REQ);
  assign ram.we    = we_q;
  assign ram.addr  = {addr_q[63:3], 3'b000};
  assign ram.be    = lane_be;
  assign ram.wdata = lane_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: byte-addressed memory model plus a
// per-cycle comparison of every controller output against expected values.
module tb_mem_access_ctrl;
  import lsu_pkg::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_access_ctrl_if cpu_if ();
  mem_ram_if         ram_if ();

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cpu   (cpu_if),
    .ram   (ram_if)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int start_cyc = 0;

  // expected outputs for the current cycle
  bit          chk_en = 1'b0;
  logic        m_busy, m_done, m_fault, m_req, m_we;
  logic [63:0] m_rdata, m_addr, m_wdata;
  logic [7:0]  m_be;

  // observations of the DUT
  int          ndone = 0;
  int          nreq = 0;
  int          last_done_rel = -1;
  logic [7:0]  cap_be;
  logic [63:0] cap_wdata;

  logic [7:0] mem [logic [63:0]];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      2'b01:   return 1;
      2'b10:   return 4;
      2'b11:   return 8;
      default: return 0;
    endcase
  endfunction

  function automatic bit legal(input logic [1:0] sz, input logic [63:0] a);
    int n;
    n = nbytes(sz);
    if (n == 0) return 1'b0;
    return (a % 64'(n)) == 64'd0;
  endfunction

  function automatic logic [7:0] mem_rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [63:0] dword_at(input logic [63:0] a);
    logic [63:0] base;
    logic [63:0] v;
    base = a & ~64'h7;
    v = '0;
    for (int i = 0; i < 8; i++) v = v | (64'(mem_rd(base + 64'(i))) << (8 * i));
    return v;
  endfunction

  function automatic logic [63:0] load_val(input logic [1:0] sz, input logic [63:0] a);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < nbytes(sz); i++) v = v | (64'(mem_rd(a + 64'(i))) << (8 * i));
    return v;
  endfunction

  task automatic store_mem(input logic [1:0] sz, input logic [63:0] a, input logic [63:0] wd);
    for (int i = 0; i < nbytes(sz); i++) mem[a + 64'(i)] = wd[8*i +: 8];
  endtask

  function automatic logic [7:0] exp_be(input logic [1:0] sz, input logic [63:0] a);
    logic [7:0] be;
    int off;
    be = '0;
    off = int'(a[2:0]);
    for (int i = 0; i < nbytes(sz); i++) be[off + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [63:0] exp_wd(input logic [1:0] sz, input logic [63:0] a, input logic [63:0] wd);
    if (nbytes(sz) == 8) return wd;
    return wd << (8 * int'(a[2:0]));
  endfunction

  // single compare process plus observation counters
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",  64'(cpu_if.busy),  64'(m_busy));
      check("done",  64'(cpu_if.done),  64'(m_done));
      check("fault", 64'(cpu_if.fault), 64'(m_fault));
      check("rdata", cpu_if.rdata,      m_rdata);
      check("ram_req", 64'(ram_if.req), 64'(m_req));
      if (m_req) begin
        check("ram_we",    64'(ram_if.we), 64'(m_we));
        check("ram_addr",  ram_if.addr,    m_addr);
        check("ram_be",    64'(ram_if.be), 64'(m_be));
        check("ram_wdata", ram_if.wdata,   m_wdata);
      end
    end
    if (cpu_if.done) begin
      ndone++;
      last_done_rel = cyc - start_cyc;
    end
    if (ram_if.req) begin
      nreq++;
      cap_be    = ram_if.be;
      cap_wdata = ram_if.wdata;
    end
  end

  task automatic access(input string tag, input logic we, input logic [1:0] sz,
                        input logic [63:0] a, input logic [63:0] wd, input int ack_at);
    bit ok;
    bit got;
    ok  = legal(sz, a);
    got = 1'b0;
    cpu_if.start        = 1'b1;
    cpu_if.mem_write_en = we;
    cpu_if.size         = sz;
    cpu_if.addr         = a;
    cpu_if.wdata        = wd;
    start_cyc = cyc;
    nreq = 0;
    tick();
    // scramble inputs: the access in flight must not follow them
    cpu_if.start        = 1'b0;
    cpu_if.mem_write_en = ~we;
    cpu_if.size         = 2'($urandom);
    cpu_if.addr         = {$urandom, $urandom};
    cpu_if.wdata        = {$urandom, $urandom};
    m_busy = 1'b1;
    if (!ok) begin
      m_done  = 1'b1;
      m_fault = 1'b1;
      m_req   = 1'b0;
      tick();
    end else begin
      m_fault = 1'b0;
      m_req   = 1'b1;
      m_we    = we;
      m_addr  = a & ~64'h7;
      m_be    = exp_be(sz, a);
      m_wdata = exp_wd(sz, a, wd);
      for (int c = 1; c <= TO; c++) begin
        if (c == ack_at) begin
          ram_if.ack   = 1'b1;
          ram_if.rdata = dword_at(a);
        end
        tick();
        ram_if.ack   = 1'b0;
        ram_if.rdata = {$urandom, $urandom};
        if (c == ack_at) begin
          got = 1'b1;
          break;
        end
      end
      m_req   = 1'b0;
      m_done  = 1'b1;
      m_fault = !got;
      if (got && !we) m_rdata = load_val(sz, a);
      if (got && we) store_mem(sz, a, wd);
      ram_if.ack = 1'b1;  // stray ack while not requesting
      tick();
      ram_if.ack = 1'b0;
    end
    m_done = 1'b0;
    m_busy = 1'b0;
    $display("[TB] %s we=%0d size=%0d addr=%h ack_at=%0d done_rel=%0d fault=%0d rdata=%h",
             tag, we, sz, a, ack_at, last_done_rel, cpu_if.fault, cpu_if.rdata);
  endtask

  initial begin
    int ndone_before;
    rst_n = 1'b1;
    cpu_if.start = 1'b0; cpu_if.mem_write_en = 1'b0; cpu_if.size = 2'b00;
    cpu_if.addr = '0; cpu_if.wdata = '0;
    ram_if.ack = 1'b0; ram_if.rdata = '0;
    m_busy = 0; m_done = 0; m_fault = 0; m_req = 0; m_we = 0;
    m_rdata = '0; m_addr = '0; m_wdata = '0; m_be = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst busy",  64'(cpu_if.busy),  64'd0);
    check("rst done",  64'(cpu_if.done),  64'd0);
    check("rst fault", 64'(cpu_if.fault), 64'd0);
    check("rst rdata", cpu_if.rdata,      64'd0);
    check("rst req",   64'(ram_if.req),   64'd0);
    check("rst we",    64'(ram_if.we),    64'd0);
    check("rst addr",  ram_if.addr,       64'd0);
    check("rst be",    64'(ram_if.be),    64'd0);
    check("rst wdata", ram_if.wdata,      64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    access("STUR dword", 1'b1, SZ_DWORD, 64'h100, 64'h8877665544332211, 1);
    access("LDURB", 1'b0, SZ_BYTE, 64'h103, 64'h0, 2);
    check("LDURB rdata", cpu_if.rdata, 64'h44);
    check("LDURB be", 64'(cap_be), 64'h08);
    check("LDURB done cycle", 64'(last_done_rel), 64'd3);

    access("STURB", 1'b1, SZ_BYTE, 64'h205, 64'hAB, 1);
    check("STURB be", 64'(cap_be), 64'h20);
    check("STURB lane", 64'(cap_wdata[47:40]), 64'hAB);
    check("STURB done cycle", 64'(last_done_rel), 64'd2);
    check("STURB rdata kept", cpu_if.rdata, 64'h44);

    access("LDUR misaligned", 1'b0, SZ_DWORD, 64'h104, 64'h0, 1);
    check("misaligned req cycles", 64'(nreq), 64'd0);
    check("misaligned done cycle", 64'(last_done_rel), 64'd1);
    check("misaligned fault held", 64'(cpu_if.fault), 64'd1);

    access("size 00", 1'b0, 2'b00, 64'h100, 64'h0, 1);
    check("size00 req cycles", 64'(nreq), 64'd0);
    check("size00 done cycle", 64'(last_done_rel), 64'd1);

    access("timeout", 1'b0, SZ_WORD, 64'h108, 64'h0, 0);
    check("timeout req cycles", 64'(nreq), 64'd16);
    check("timeout done cycle", 64'(last_done_rel), 64'd17);
    check("timeout fault", 64'(cpu_if.fault), 64'd1);

    access("ack on last", 1'b0, SZ_WORD, 64'h104, 64'h0, TO);
    check("last ack fault", 64'(cpu_if.fault), 64'd0);
    check("last ack done cycle", 64'(last_done_rel), 64'd17);
    check("last ack rdata", cpu_if.rdata, 64'h88776655);

    access("STUR word", 1'b1, SZ_WORD, 64'h20C, 64'h1234_5678_CAFE_BABE, 3);
    access("LDUR dword", 1'b0, SZ_DWORD, 64'h208, 64'h0, 1);
    check("dword after word store", cpu_if.rdata[63:32], 64'hCAFEBABE);
    access("LDUR word misaligned", 1'b0, SZ_WORD, 64'h106, 64'h0, 1);
    access("LDURB hi lane", 1'b0, SZ_BYTE, 64'h107, 64'h0, 4);

    // reset in the middle of a request
    cpu_if.start = 1'b1; cpu_if.mem_write_en = 1'b0; cpu_if.size = SZ_DWORD;
    cpu_if.addr = 64'h400; cpu_if.wdata = 64'h0;
    tick();
    cpu_if.start = 1'b0;
    m_busy = 1; m_req = 1; m_fault = 0; m_we = 0;
    m_addr = 64'h400; m_be = 8'hFF; m_wdata = 64'h0;
    tick();
    ndone_before = ndone;
    #2 rst_n = 1'b0;
    m_busy = 0; m_done = 0; m_fault = 0; m_req = 0; m_rdata = '0;
    #1;
    check("midreset busy",  64'(cpu_if.busy),  64'd0);
    check("midreset req",   64'(ram_if.req),   64'd0);
    check("midreset rdata", cpu_if.rdata,      64'd0);
    check("midreset be",    64'(ram_if.be),    64'd0);
    check("midreset addr",  ram_if.addr,       64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    tick();
    check("midreset no done", 64'(ndone), 64'(ndone_before));
    access("LDUR after reset", 1'b0, SZ_DWORD, 64'h100, 64'h0, 3);
    check("after reset rdata", cpu_if.rdata, 64'h8877665544332211);

    // start held high across DONE, inputs changing, ack held high throughout
    ndone = 0;
    nreq = 0;
    ram_if.ack = 1'b1;
    ram_if.rdata = dword_at(64'h300);
    for (int c = 0; c < 9; c++) begin
      int k;
      k = c / 3;
      cpu_if.start = 1'b1;
      if (c % 3 == 0) begin
        cpu_if.addr = 64'h300 + 64'(k); cpu_if.size = SZ_BYTE;
        cpu_if.mem_write_en = 1'b0; cpu_if.wdata = 64'h0;
        m_busy = 0; m_done = 0; m_req = 0;
      end else begin
        cpu_if.addr = 64'hDEAD_BEEF_0000_0FFF; cpu_if.size = SZ_DWORD;
        cpu_if.mem_write_en = 1'b1; cpu_if.wdata = {$urandom, $urandom};
        if (c % 3 == 1) begin
          m_busy = 1; m_req = 1; m_fault = 0; m_we = 0;
          m_addr = 64'h300; m_be = exp_be(SZ_BYTE, 64'h300 + 64'(k)); m_wdata = 64'h0;
        end else begin
          m_req = 0; m_done = 1;
          m_rdata = load_val(SZ_BYTE, 64'h300 + 64'(k));
        end
      end
      tick();
    end
    cpu_if.start = 1'b0;
    ram_if.ack = 1'b0;
    m_done = 0; m_busy = 0;
    tick();
    tick();
    check("held start done pulses", 64'(ndone), 64'd3);
    check("held start req cycles", 64'(nreq), 64'd3);
    $display("[TB] held-start burst: %0d accesses, rdata=%h", ndone, cpu_if.rdata);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
